mux_scanner: RTL and testbench

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner.sv | 94 +++++++++
 tb/tb_mux_scanner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scanner.sv
// mux_scanner: walks a 4:1 mux select, lets each channel settle, and captures one 4-bit frame per scan.
// Completed frames are handed off with a valid/ack pair; a frame that arrives while one is pending is dropped and flagged.
module mux_scanner #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_out,
  input  logic       frame_ack,
  output logic [1:0] sel,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy,
  output logic       overrun
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [3:0] LAST      = 4'(SETTLE - 1);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] frame_q, frame_d;
  logic       fv_q, fv_d, ovr_q, ovr_d, busy_q, busy_d;
  logic       done, take;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = fv_q;
    ovr_d    = ovr_q;
    done     = (state_q == ST_SAMPLE) && (sel_q == 2'd3);
    take     = done && (!fv_q || frame_ack);
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
        sel_d   = '0;
        ovr_d   = 1'b0;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cnt_d = '0;
        sel_d = sel_q + 2'd1;
        if (sel_q != 2'd3) begin
          shadow_d[sel_q] = mux_out;
          state_d         = ST_SETTLE;
        end else state_d = continuous ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // a completed frame either replaces the pending one or is dropped as an overrun
    if (take) begin
      frame_d = {mux_out, shadow_q};
      fv_d    = 1'b1;
    end else if (done) ovr_d = 1'b1;
    else if (fv_q && frame_ack) fv_d = 1'b0;
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end
  assign sel         = sel_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: models the 4:1 mux as in_v[sel]; expected frames are queued at stimulus time and popped when a new frame appears.
module tb_mux_scanner;
  localparam int ST = 2;
  localparam int CH = ST + 1;
  logic clk = 0, rst_n = 0, start = 0, continuous = 0;
  logic force_ack = 0, auto_ack = 0, auto_ack_r = 0;
  logic [3:0] in_v = '0;
  logic mux_out, frame_ack, frame_valid, busy, overrun;
  logic [1:0] sel;
  logic [3:0] frame;
  logic fv_p = 0;
  logic [3:0] fr_p = '0;
  logic [3:0] sb[$];
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  assign mux_out   = in_v[sel];
  assign frame_ack = auto_ack_r | force_ack;
  mux_scanner #(.SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .mux_out(mux_out), .frame_ack(frame_ack), .sel(sel), .frame(frame),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // a new frame is visible when valid rises or the held frame is replaced
  always @(negedge clk) begin
    if (rst_n && frame_valid && (!fv_p || frame != fr_p)) begin
      if (sb.size() == 0) check("spurious_frame", 32'(sb.size()), 1);
      else check("frame", frame, sb.pop_front());
    end
    fv_p       <= frame_valid;
    fr_p       <= frame;
    auto_ack_r <= auto_ack && frame_valid && !auto_ack_r;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_empty(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sb.size()), 0);
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(2);
    check("rst_sel", sel, 0);
    check("rst_frame", frame, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1;
    tick(3);
    check("idle_after_rst", busy, 0);
    // single shot
    in_v = 4'b1010;
    sb.push_back(4'b1010);
    pulse_start();
    for (int j = 0; j < 4 * CH; j++) begin
      check("t1_sel", sel, 32'(j / CH));
      if (j == 4 * CH - 1) check("t1_early_fv", frame_valid, 0);
      tick(1);
    end
    check("t1_fv", frame_valid, 1);
    check("t1_frame", frame, 4'b1010);
    check("t1_busy", busy, 0);
    check("t1_sel_wrap", sel, 0);
    wait_empty("t1_sb", 2);
    auto_ack = 1;
    tick(2);
    check("t1_ack_clr", frame_valid, 0);
    // continuous with ack, input changed during second frame's channel 0 settle
    continuous = 1;
    in_v = 4'b0110;
    sb.push_back(4'b0110);
    pulse_start();
    wait_empty("t2_f1", 20);
    in_v = 4'b1001;
    sb.push_back(4'b1001);
    check("t2_wrap_sel", sel, 0);
    check("t2_busy", busy, 1);
    tick(3);
    continuous = 0;
    wait_empty("t2_f2", 20);
    wait_idle("t2_idle", 20);
    check("t2_ovr", overrun, 0);
    // continuous without ack -> overrun
    tick(2);
    auto_ack = 0;
    continuous = 1;
    in_v = 4'b1111;
    sb.push_back(4'b1111);
    pulse_start();
    wait_empty("t3_f1", 20);
    in_v = 4'b0000;
    for (int k = 0; k < 20 && !overrun; k++) tick(1);
    check("t3_ovr", overrun, 1);
    check("t3_frame_kept", frame, 4'b1111);
    check("t3_fv", frame_valid, 1);
    continuous = 0;
    wait_idle("t3_idle", 20);
    check("t3_ovr_sticky", overrun, 1);
    // start in idle clears overrun; ack lands on the completion cycle
    in_v = 4'b0011;
    sb.push_back(4'b0011);
    pulse_start();
    check("t4_ovr_clr", overrun, 0);
    tick(4 * CH - 1);
    force_ack = 1;
    tick(1);
    force_ack = 0;
    check("t4_frame", frame, 4'b0011);
    check("t4_fv", frame_valid, 1);
    check("t4_ovr", overrun, 0);
    wait_empty("t4_sb", 2);
    // async reset mid-frame
    auto_ack = 1;
    tick(3);
    in_v = 4'b0101;
    pulse_start();
    for (int k = 0; k < 20 && sel != 2'd2; k++) tick(1);
    check("t5_reach_sel2", sel, 2);
    #2 rst_n = 0;
    #1;
    check("t5_sel", sel, 0);
    check("t5_frame", frame, 0);
    check("t5_fv", frame_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_ovr", overrun, 0);
    @(negedge clk);
    rst_n = 1;
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        tick(1);
        if (frame_valid || busy) seen++;
      end
      check("t5_quiet", 32'(seen), 0);
    end
    sb.push_back(4'b0101);
    pulse_start();
    wait_empty("t5_refire", 20);
    wait_idle("t5_idle", 5);
    // start held high: one frame per accepted start, sequence unperturbed
    in_v = 4'b1100;
    sb.push_back(4'b1100);
    sb.push_back(4'b1100);
    start = 1;
    tick(1);
    for (int j = 0; j < 4 * CH; j++) begin
      check("t6_sel", sel, 32'(j / CH));
      tick(1);
    end
    tick(7);
    start = 0;
    wait_empty("t6_frames", 30);
    wait_idle("t6_idle", 20);
    tick(30);
    check("t6_still_idle", busy, 0);
    check("t6_ovr", overrun, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
